// File: rtl/temp_conv_sched_if.sv
// Handshake and data signals for the two-channel Celsius-to-Fahrenheit scheduler.
// The requesting side uses the master modport; the scheduler uses the slave modport.
interface temp_conv_sched_if;
  logic       req_a;
  logic [7:0] temp_a;
  logic       gnt_a;
  logic       done_a;
  logic [7:0] temp_b;
  logic       req_c;
  logic [7:0] temp_c;
  logic       gnt_c;
  logic       done_c;
  logic [7:0] temp_d;
  logic       busy;

  modport master (
    output req_a, temp_a, req_c, temp_c,
    input  gnt_a, done_a, temp_b, gnt_c, done_c, temp_d, busy
  );

  modport slave (
    input  req_a, temp_a, req_c, temp_c,
    output gnt_a, done_a, temp_b, gnt_c, done_c, temp_d, busy
  );
endinterface

// File: rtl/temp_conv_sched.sv
// Two-channel temperature converter sharing one multi-cycle conversion unit.
// Round-robin arbitration, LAT cycles of conversion, one write-back cycle per job.
module temp_conv_sched #(
  parameter int unsigned LAT = 4
) (
  input logic              clk,
  input logic              rst_n,
  temp_conv_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CONV, WB} state_t;

  state_t      state, state_d;
  logic [3:0]  cnt, cnt_d;
  logic        grant, pick_c, wb_load;
  logic        sel_c;   // channel of the job in flight
  logic        last_c;  // last-served channel was C
  logic [7:0]  op;
  logic [11:0] scaled;
  logic [7:0]  result;
  logic        gnt_a_q, gnt_c_q, done_a_q, done_c_q;
  logic [7:0]  temp_b_q, temp_d_q;

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    grant   = 1'b0;
    pick_c  = 1'b0;
    wb_load = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req_a || bus.req_c) begin
          grant   = 1'b1;
          pick_c  = bus.req_c && !(bus.req_a && last_c);
          cnt_d   = 4'(LAT - 1);
          state_d = CONV;
        end
      end
      CONV: begin
        if (cnt == 4'd0) begin
          wb_load = 1'b1;
          state_d = WB;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Max intermediate is 255*9/5+32 = 491, so 12 bits never overflow.
  always_comb begin
    scaled = ({4'd0, op} * 12'd9) / 12'd5 + 12'd32;
    result = (scaled > 12'd255) ? 8'hFF : scaled[7:0];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      sel_c    <= 1'b0;
      last_c   <= 1'b1;
      op       <= 8'd0;
      gnt_a_q  <= 1'b0;
      gnt_c_q  <= 1'b0;
      done_a_q <= 1'b0;
      done_c_q <= 1'b0;
      temp_b_q <= 8'd0;
      temp_d_q <= 8'd0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      gnt_a_q  <= grant && !pick_c;
      gnt_c_q  <= grant && pick_c;
      done_a_q <= wb_load && !sel_c;
      done_c_q <= wb_load && sel_c;
      if (grant) begin
        op     <= pick_c ? bus.temp_c : bus.temp_a;
        sel_c  <= pick_c;
        last_c <= pick_c;
      end
      if (wb_load && !sel_c) temp_b_q <= result;
      if (wb_load && sel_c)  temp_d_q <= result;
    end
  end

  assign bus.gnt_a  = gnt_a_q;
  assign bus.gnt_c  = gnt_c_q;
  assign bus.done_a = done_a_q;
  assign bus.done_c = done_c_q;
  assign bus.temp_b = temp_b_q;
  assign bus.temp_d = temp_d_q;
  assign bus.busy   = (state != IDLE);

endmodule

// File: tb/tb_temp_conv_sched.sv
// Bench for temp_conv_sched: a LAT=4 and a LAT=1 instance checked every cycle
// against a job-timeline model, plus directed literal expectations.
module tb_temp_conv_sched;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  bit   chk_en = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  temp_conv_sched_if bus4 ();
  temp_conv_sched_if bus1 ();

  temp_conv_sched #(.LAT(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  temp_conv_sched #(.LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int f_of_c(input int c);
    int f;
    f = c * 9 / 5 + 32;
    return (f > 255) ? 255 : f;
  endfunction

  function automatic logic arb_c(input logic ra, input logic rc, input logic last_c);
    return rc && !(ra && last_c);
  endfunction

  // Model: el = cycles elapsed since the grant edge (-1 when idle).
  // Cycles 0..lat-1 convert, cycle lat writes back, then one idle cycle.
  int         lat [2] = '{4, 1};
  int         el  [2];
  logic       m_ch[2];
  logic [7:0] m_op[2];
  logic       m_last_c[2];
  logic [7:0] m_b [2];
  logic [7:0] m_d [2];
  logic       m_ra[2], m_rc[2];
  logic [7:0] m_ta[2], m_tc[2];

  assign m_ra[0] = bus4.req_a;  assign m_rc[0] = bus4.req_c;
  assign m_ta[0] = bus4.temp_a; assign m_tc[0] = bus4.temp_c;
  assign m_ra[1] = bus1.req_a;  assign m_rc[1] = bus1.req_c;
  assign m_ta[1] = bus1.temp_a; assign m_tc[1] = bus1.temp_c;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        el[i] <= -1; m_ch[i] <= 1'b0; m_op[i] <= 8'd0;
        m_last_c[i] <= 1'b1; m_b[i] <= 8'd0; m_d[i] <= 8'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (el[i] < 0) begin
          if (m_ra[i] || m_rc[i]) begin
            el[i]       <= 0;
            m_ch[i]     <= arb_c(m_ra[i], m_rc[i], m_last_c[i]);
            m_last_c[i] <= arb_c(m_ra[i], m_rc[i], m_last_c[i]);
            m_op[i]     <= arb_c(m_ra[i], m_rc[i], m_last_c[i]) ? m_tc[i] : m_ta[i];
          end
        end else if (el[i] == lat[i]) begin
          el[i] <= -1;
        end else begin
          el[i] <= el[i] + 1;
          if (el[i] + 1 == lat[i]) begin
            if (m_ch[i]) m_d[i] <= 8'(f_of_c(int'(m_op[i])));
            else         m_b[i] <= 8'(f_of_c(int'(m_op[i])));
          end
        end
      end
    end
  end

  task automatic cmp(input int i, input logic ga, input logic gc, input logic da,
                     input logic dc, input logic bz, input logic [7:0] tb, input logic [7:0] td);
    string p;
    p = (i == 0) ? "L4" : "L1";
    check({p, " gnt_a"},  {31'd0, ga}, {31'd0, (el[i] == 0) && !m_ch[i]});
    check({p, " gnt_c"},  {31'd0, gc}, {31'd0, (el[i] == 0) && m_ch[i]});
    check({p, " done_a"}, {31'd0, da}, {31'd0, (el[i] == lat[i]) && !m_ch[i]});
    check({p, " done_c"}, {31'd0, dc}, {31'd0, (el[i] == lat[i]) && m_ch[i]});
    check({p, " busy"},   {31'd0, bz}, {31'd0, el[i] >= 0});
    check({p, " temp_b"}, {24'd0, tb}, {24'd0, m_b[i]});
    check({p, " temp_d"}, {24'd0, td}, {24'd0, m_d[i]});
    check({p, " gnt excl"}, {31'd0, ga && gc}, 32'd0);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp(0, bus4.gnt_a, bus4.gnt_c, bus4.done_a, bus4.done_c, bus4.busy, bus4.temp_b, bus4.temp_d);
      cmp(1, bus1.gnt_a, bus1.gnt_c, bus1.done_a, bus1.done_c, bus1.busy, bus1.temp_b, bus1.temp_d);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic conv_c(input logic [7:0] c, input logic [7:0] exp);
    bus4.temp_c = c;
    bus4.req_c  = 1'b1;
    cyc(1);
    check("sweep gnt_c", {31'd0, bus4.gnt_c}, 32'd1);
    bus4.req_c = 1'b0;
    cyc(4);
    check("sweep done_c", {31'd0, bus4.done_c}, 32'd1);
    check($sformatf("sweep temp_d(%0d)", c), {24'd0, bus4.temp_d}, {24'd0, exp});
    cyc(1);
  endtask

  initial begin
    bus4.req_a = 1'b0; bus4.temp_a = 8'd0; bus4.req_c = 1'b0; bus4.temp_c = 8'd0;
    bus1.req_a = 1'b0; bus1.temp_a = 8'd0; bus1.req_c = 1'b0; bus1.temp_c = 8'd0;
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    cyc(2);
    check("reset busy",   {31'd0, bus4.busy}, 32'd0);
    check("reset temp_b", {24'd0, bus4.temp_b}, 32'd0);
    check("reset temp_d", {24'd0, bus4.temp_d}, 32'd0);
    rst_n = 1'b1;

    // Single channel-A job: 100 C -> 212 F
    cyc(1);
    bus4.temp_a = 8'd100;
    bus4.req_a  = 1'b1;
    cyc(1);
    check("A100 gnt_a", {31'd0, bus4.gnt_a}, 32'd1);
    bus4.req_a = 1'b0;
    cyc(4);
    check("A100 done_a", {31'd0, bus4.done_a}, 32'd1);
    check("A100 temp_b", {24'd0, bus4.temp_b}, 32'd212);
    check("A100 temp_d", {24'd0, bus4.temp_d}, 32'd0);
    cyc(2);

    // Operand sweep on channel C including the saturation boundary
    conv_c(8'd0,   8'd32);
    conv_c(8'd37,  8'd98);
    conv_c(8'd124, 8'd255);
    conv_c(8'd125, 8'd255);
    conv_c(8'd255, 8'd255);

    // Operand changed after grant must not affect the result in flight
    bus4.temp_c = 8'd10;
    bus4.req_c  = 1'b1;
    cyc(1);
    bus4.req_c = 1'b0;
    cyc(1);
    bus4.temp_c = 8'd200;
    cyc(3);
    check("inflight done_c", {31'd0, bus4.done_c}, 32'd1);
    check("inflight temp_d", {24'd0, bus4.temp_d}, 32'd50);
    cyc(1);

    // Both channels requesting from reset: A, C, A, C every LAT+2 cycles
    @(negedge clk); #2 rst_n = 1'b0;
    bus4.temp_a = 8'd20; bus4.temp_c = 8'd30;
    bus4.req_a = 1'b1;   bus4.req_c = 1'b1;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    check("rr 1 gnt_a", {31'd0, bus4.gnt_a}, 32'd1);
    cyc(6);
    check("rr 2 gnt_c", {31'd0, bus4.gnt_c}, 32'd1);
    cyc(6);
    check("rr 3 gnt_a", {31'd0, bus4.gnt_a}, 32'd1);
    cyc(6);
    check("rr 4 gnt_c", {31'd0, bus4.gnt_c}, 32'd1);
    bus4.req_a = 1'b0; bus4.req_c = 1'b0;
    cyc(6);
    check("rr temp_b", {24'd0, bus4.temp_b}, 32'd68);
    check("rr temp_d", {24'd0, bus4.temp_d}, 32'd86);

    // Reset during CONV aborts the channel-A job
    bus4.temp_a = 8'd50;
    bus4.req_a  = 1'b1;
    cyc(1);
    bus4.req_a = 1'b0;
    cyc(2);
    #2 rst_n = 1'b0;
    #1;
    check("abort busy",   {31'd0, bus4.busy},   32'd0);
    check("abort temp_b", {24'd0, bus4.temp_b}, 32'd0);
    check("abort temp_d", {24'd0, bus4.temp_d}, 32'd0);
    cyc(1);
    rst_n = 1'b1;
    cyc(8);
    check("abort no result", {24'd0, bus4.temp_b}, 32'd0);

    // LAT=1 back-to-back on channel A: grant every 3 cycles
    bus1.temp_a = 8'd5;
    bus1.req_a  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      check("L1 b2b gnt_a", {31'd0, bus1.gnt_a}, 32'd1);
      cyc(1);
      check("L1 b2b done_a", {31'd0, bus1.done_a}, 32'd1);
      check("L1 b2b temp_b", {24'd0, bus1.temp_b}, 32'd41);
      cyc(1);
      check("L1 b2b idle busy", {31'd0, bus1.busy}, 32'd0);
    end
    bus1.req_a = 1'b0;
    cyc(4);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/temp_conv_sched.md
TEMP_CONV_SCHED -- requirements
Module: temp_conv_sched

Interface
REQ-001 Parameter: LAT, default 4, number of CONV-state cycles per conversion; legal range 1..15.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: req_a  input  1  channel A conversion request, level, held until grant.
REQ-005 Port: temp_a  input  8  channel A unsigned Celsius operand, stable while req_a high.
REQ-006 Port: gnt_a  output  1  one-cycle pulse: channel A operand accepted.
REQ-007 Port: done_a  output  1  one-cycle pulse: temp_b updated.
REQ-008 Port: temp_b  output  8  channel A Fahrenheit result, held between conversions.
REQ-009 Port: req_c  input  1  channel C request, same rules as req_a.
REQ-010 Port: temp_c  input  8  channel C operand.
REQ-011 Port: gnt_c  output  1  channel C grant pulse.
REQ-012 Port: done_c  output  1  channel C done pulse.
REQ-013 Port: temp_d  output  8  channel C result.
REQ-014 Port: busy  output  1  high whenever FSM is not IDLE.

Function
REQ-015 FSM shall have states IDLE, CONV, WB; one conversion unit shared by both channels.
REQ-016 IDLE: at an edge with any req sampled high, the FSM shall select a channel, latch its operand, load cycle counter with LAT-1 and enter CONV; else remain IDLE.
REQ-017 Arbitration shall be round-robin: if both requests are high, the channel not served last wins; a single requester always wins.
REQ-018 The last-served pointer shall update only on grant.
REQ-019 gnt_x shall be high exactly during the first CONV cycle of the conversion for channel x.
REQ-020 CONV shall last exactly LAT cycles (counter decrements to 0), then enter WB.
REQ-021 Result = floor(op*9/5) + 32, computed at >=12-bit width, saturated to 255 (op >= 125 yields 255).
REQ-022 WB (one cycle): result register of the served channel (temp_b or temp_d) updates, done_x high for that cycle only; next state IDLE.
REQ-023 The unserved channel's result register and done shall not change during WB.
REQ-024 Latency: request sampled at edge k -> gnt cycle k..k+1, done and valid result at cycle k+LAT+1; grant-to-grant minimum LAT+2 cycles.
REQ-025 Requests arriving during CONV/WB shall be held off (no grant) and arbitrated at the next IDLE edge.
REQ-026 Operand changes after grant shall not affect the result in flight.
REQ-027 req_x held high after its done shall start a new conversion (subject to arbitration); req_x dropped before grant shall cause no conversion.
REQ-028 gnt_a/gnt_c shall never be high in the same cycle; likewise done_a/done_c.

Reset
REQ-029 rst_n low shall asynchronously force: FSM IDLE, counter 0, gnt_a/gnt_c/done_a/done_c/busy 0, temp_b/temp_d 0, last-served pointer = C (A wins first tie).
REQ-030 Reset asserted mid-CONV or in WB shall abort the conversion; no done pulse shall follow deassertion.
REQ-031 After rst_n rises, the first grant shall occur no earlier than the first rising edge at which rst_n is high.

Verification
REQ-032 LAT=4, req_a with temp_a=100 -> gnt_a 1 cycle, done_a 5 cycles after the request edge, temp_b=212, temp_d stays 0.
REQ-033 Operand sweep 0, 37, 124, 125, 255 on channel C -> temp_d = 32, 98, 255, 255, 255.
REQ-034 req_a and req_c both high from reset, held -> grants alternate A, C, A, C with spacing LAT+2; never both grants in one cycle.
REQ-035 Reset pulse during CONV of a channel-A job -> all outputs 0 immediately, no done_a afterwards, temp_b=0.
REQ-036 temp_c changed from 10 to 200 one cycle after gnt_c -> temp_d=50 (from 10), not 255.
REQ-037 LAT=1 back-to-back on channel A -> gnt_a every 3 cycles, busy low only on IDLE cycles.
